sif_xa_initiator: RTL and testbench

- Host-side initiator for the SIF xa bus. It drives the xa_wr_s, xa_rd_s, xa_addr and xa_data_wr pins into the sif block and captures xa_data_rd.
- Accepts queued write/read commands from a simple valid/ready command port, sequences single-cycle xa strobes with a guaranteed idle gap, and returns read data on a response port.
- Replaces hand-driven clocking-block stimulus in benches; also usable as synthesizable host logic.

---
 rtl/sif_xa_initiator.sv | 169 ++++++++++++++++
 tb/tb_sif_xa_initiator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sif_xa_initiator.sv
// sif_xa_initiator: queues write/read commands and issues them as single-cycle xa strobes
// separated by idle cycles. Define SIF_XA_WRITE_VERIFY_EN to read back every write and flag mismatches on verr.
module sif_xa_initiator #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              xa_wr_s,
  output logic              xa_rd_s,
  output logic [ADDR_W-1:0] xa_addr,
  output logic [DATA_W-1:0] xa_data_wr,
  input  logic [DATA_W-1:0] xa_data_rd,
  output logic              verr
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CMD_W = 1 + ADDR_W + DATA_W;
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, GAP} state_t;

  state_t           state_reg;
  logic [CMD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic             cmd_ready_reg;
  logic [2:0]       wait_cnt_reg;
  logic [CMD_W-1:0] head;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  assign push        = cmd_valid && cmd_ready_reg;
  assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
  assign pop         = (state_reg == IDLE) && !fifo_empty;
  assign wr_ptr_next = wr_ptr_reg + PTR_W'(push);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
  assign head        = fifo_mem[rd_ptr_reg[IDX_W-1:0]];

  assign cmd_ready = cmd_ready_reg;
  assign busy      = !fifo_empty || (state_reg != IDLE);

  // Storage has no reset so it maps onto RAM; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[IDX_W-1:0]] <= {cmd_wr, cmd_addr, cmd_wdata};
    end
  end

  // cmd_ready is computed from the next pointers, so a pop into a full FIFO reopens it one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      cmd_ready_reg <= 1'b1;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      cmd_ready_reg <= !((wr_ptr_next[PTR_W-1] != rd_ptr_next[PTR_W-1]) &&
                         (wr_ptr_next[IDX_W-1:0] == rd_ptr_next[IDX_W-1:0]));
    end
  end

`ifdef SIF_XA_WRITE_VERIFY_EN
  logic verify_reg;
  logic vfy_pending_reg;
  logic verr_reg;
  assign verr = verr_reg;
`else
  assign verr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      xa_wr_s      <= 1'b0;
      xa_rd_s      <= 1'b0;
      xa_addr      <= '0;
      xa_data_wr   <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
`ifdef SIF_XA_WRITE_VERIFY_EN
      verify_reg      <= 1'b0;
      vfy_pending_reg <= 1'b0;
      verr_reg        <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            xa_addr <= head[DATA_W +: ADDR_W];
`ifdef SIF_XA_WRITE_VERIFY_EN
            verify_reg <= 1'b0;
`endif
            if (head[CMD_W-1]) begin
              xa_data_wr <= head[DATA_W-1:0];
              xa_wr_s    <= 1'b1;
              state_reg  <= WR;
            end else begin
              xa_rd_s   <= 1'b1;
              state_reg <= RD;
            end
          end
        end
        WR: begin
          xa_wr_s   <= 1'b0;
          state_reg <= GAP;
`ifdef SIF_XA_WRITE_VERIFY_EN
          vfy_pending_reg <= 1'b1;
`endif
        end
        RD: begin
          xa_rd_s      <= 1'b0;
          wait_cnt_reg <= LAT_LOAD;
          state_reg    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_cnt_reg == 3'd0) begin
`ifdef SIF_XA_WRITE_VERIFY_EN
            // The verify readback compares against the still-held write data and never responds.
            if (verify_reg) begin
              if (xa_data_rd != xa_data_wr) verr_reg <= 1'b1;
            end else
`endif
            begin
              rsp_rdata <= xa_data_rd;
              rsp_valid <= 1'b1;
            end
            state_reg <= GAP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 3'd1;
          end
        end
        GAP: begin
`ifdef SIF_XA_WRITE_VERIFY_EN
          if (vfy_pending_reg) begin
            vfy_pending_reg <= 1'b0;
            verify_reg      <= 1'b1;
            xa_rd_s         <= 1'b1;
            state_reg       <= RD;
          end else begin
            state_reg <= IDLE;
          end
`else
          state_reg <= IDLE;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sif_xa_initiator.sv
// Randomized self-checking bench for sif_xa_initiator: a sif memory model on the xa pins and a
// command-order scoreboard that predicts every strobe, every response and the FIFO occupancy.
module tb_sif_xa_initiator;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_wr = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              xa_wr_s;
  logic              xa_rd_s;
  logic [ADDR_W-1:0] xa_addr;
  logic [DATA_W-1:0] xa_data_wr;
  logic [DATA_W-1:0] xa_data_rd = '0;
  logic              verr;

  sif_xa_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr),
    .xa_data_wr(xa_data_wr), .xa_data_rd(xa_data_rd), .verr(verr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit         wr;
    bit         vfy;
    logic [7:0] addr;
    logic [7:0] data;
  } xa_t;

  xa_t        exp_xa[$];
  logic [7:0] exp_rsp[$];
  int         rd_cyc[$];
  logic [7:0] model_mem [256];
  logic [7:0] sif_mem [256];
  int         acc_cnt = 0;
  int         iss_cnt = 0;
  int         cyc = 0;
  int         last_strobe = -1;
  bit         saw_full = 0;
  bit         corrupt_rd = 0;
  logic [7:0] last_rsp = '0;
  logic [7:0] last_addr = '0;

  // sif model: data is valid only in the cycle that ends RD_LAT cycles after the strobe.
  bit         rd_pend = 0;
  int         rd_age = 0;
  logic [7:0] rd_a = '0;
  always @(posedge clk) begin
    if (xa_wr_s) sif_mem[xa_addr] = xa_data_wr;
    if (xa_rd_s) begin
      rd_pend = 1; rd_age = 0; rd_a = xa_addr;
    end else if (rd_pend) begin
      rd_age++;
    end
    #1;
    if (rd_pend && rd_age == RD_LAT - 1) begin
      xa_data_rd = sif_mem[rd_a] ^ {7'b0, corrupt_rd};
      rd_pend = 0;
    end else begin
      xa_data_rd = 8'($urandom);
    end
  end

  xa_t mon_e;
  int  mon_t;
  int  occ;
  bit  strobe_now;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      strobe_now = xa_wr_s || xa_rd_s;
      if (strobe_now) begin
        check("xa_overlap", 32'(xa_wr_s & xa_rd_s), 32'd0);
        if (last_strobe >= 0) check("strobe_gap", 32'(cyc - last_strobe >= 2), 32'd1);
        last_strobe = cyc;
        last_addr = xa_addr;
        $display("xa %s addr=0x%02h data=0x%02h", xa_wr_s ? "WR" : "RD", xa_addr,
                 xa_wr_s ? xa_data_wr : 8'h00);
        if (exp_xa.size() == 0) begin
          check("xa_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_xa.pop_front();
          check("xa_kind", 32'(xa_wr_s), 32'(mon_e.wr));
          check("xa_addr", 32'(xa_addr), 32'(mon_e.addr));
          if (mon_e.wr) check("xa_wdata", 32'(xa_data_wr), 32'(mon_e.data));
          else if (!mon_e.vfy) rd_cyc.push_back(cyc);
          if (!mon_e.vfy) iss_cnt++;
        end
      end
      if (rsp_valid) begin
        $display("rsp rdata=0x%02h", rsp_rdata);
        if (rd_cyc.size() == 0 || exp_rsp.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_t = rd_cyc.pop_front();
          check("rsp_latency", 32'(cyc - mon_t), 32'(RD_LAT + 1));
          last_rsp = exp_rsp.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(last_rsp));
        end
      end
      occ = acc_cnt - iss_cnt;
      check("cmd_ready", 32'(cmd_ready), 32'(occ < DEPTH));
      if (!cmd_ready) saw_full = 1;
      if (occ > 0 || strobe_now) check("busy", 32'(busy), 32'd1);
    end
  end

  task automatic send(input bit wr, input logic [7:0] a, input logic [7:0] d);
    int  waited = 0;
    bit  done = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    while (!done) begin
      @(posedge clk);
      if (cmd_ready) begin
        done = 1;
        acc_cnt++;
        if (wr) begin
          model_mem[a] = d;
          exp_xa.push_back('{1'b1, 1'b0, a, d});
`ifdef SIF_XA_WRITE_VERIFY_EN
          exp_xa.push_back('{1'b0, 1'b1, a, d});
`endif
        end else begin
          exp_xa.push_back('{1'b0, 1'b0, a, 8'h00});
          exp_rsp.push_back(model_mem[a]);
        end
      end else if (++waited > 500) begin
        check("accept_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_xa.size() != 0 || rd_cyc.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 2000), 32'd1);
    @(negedge clk);
    check("rsp_missing", 32'(exp_rsp.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("xa_addr_hold", 32'(xa_addr), 32'(last_addr));
    check("rsp_rdata_hold", 32'(rsp_rdata), 32'(last_rsp));
  endtask

  // Caller is positioned just after a rising edge; rst is seen at the next three edges.
  task automatic do_reset();
    #1 rst = 1'b1;
    cmd_valid = 1'b0;
    exp_xa.delete(); exp_rsp.delete(); rd_cyc.delete();
    acc_cnt = 0; iss_cnt = 0; last_strobe = -1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = sif_mem[i];
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_xa_wr_s", 32'(xa_wr_s), 32'd0);
    check("rst_xa_rd_s", 32'(xa_rd_s), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_verr", 32'(verr), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      sif_mem[i] = v;
      model_mem[i] = v;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();
    check("rst_xa_addr", 32'(xa_addr), 32'd0);
    check("rst_xa_data_wr", 32'(xa_data_wr), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);

    // Single write then a read of the same location.
    send(1'b1, 8'h12, 8'hA5);
    drain();
    send(1'b0, 8'h12, 8'h00);
    drain();
    check("single_read_data", 32'(last_rsp), 32'hA5);

    // Mixed ordering.
    send(1'b1, 8'h01, 8'h11);
    send(1'b0, 8'h01, 8'h00);
    send(1'b1, 8'h02, 8'h22);
    send(1'b0, 8'h02, 8'h00);
    drain();
    check("mixed_last_rdata", 32'(last_rsp), 32'h22);

    // Back-to-back writes must fill the FIFO and stall the source.
    saw_full = 0;
    for (int i = 0; i < 8; i++) send(1'b1, 8'(8'h20 + i), 8'($urandom));
    drain();
    check("fifo_full_seen", 32'(saw_full), 32'd1);

    // Randomized traffic over a small address window so reads hit recent writes.
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    check("verr_clean", 32'(verr), 32'd0);

    // Reset while a read is waiting for data: nothing may come out afterwards.
    send(1'b0, 8'h40, 8'h00);
    n = 0;
    while (!xa_rd_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midrd_strobe_seen", 32'(xa_rd_s), 32'd1);
    @(posedge clk);
    do_reset();
    check_reset_state();
    for (int i = 0; i < RD_LAT + 3; i++) begin
      @(negedge clk);
      check("midrd_no_rsp", 32'(rsp_valid), 32'd0);
      check("midrd_no_strobe", 32'(xa_rd_s | xa_wr_s), 32'd0);
    end

`ifdef SIF_XA_WRITE_VERIFY_EN
    corrupt_rd = 1;
    send(1'b1, 8'h05, 8'h3C);
    drain();
    corrupt_rd = 0;
    check("verr_set", 32'(verr), 32'd1);
    send(1'b0, 8'h05, 8'h00);
    drain();
    check("verr_sticky", 32'(verr), 32'd1);
    check("verify_rd_data", 32'(last_rsp), 32'h3C);
`else
    check("verr_tied", 32'(verr), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
